// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch path of the
// single-cycle ARMv8 CPU.
package cpu_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    // Low PC bits that must be zero for a legal A64 instruction address.
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    // True when the address is a legal 4-byte-aligned instruction address.
    function automatic logic isAligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] & PC_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer. Holds the PC,
// fetches one instruction word per PC over a valid/ready request and a
// response strobe, presents it to decode, and advances to the externally
// computed NextPC when the datapath retires the held instruction. A
// misaligned NextPC parks the unit in a terminal fault state until reset.
module pc_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic                CLK,
    input  logic                resetl,

    input  logic [ADDR_W-1:0]   NextPC,
    input  logic                pc_load,
    output logic [ADDR_W-1:0]   CurrentPC,

    output logic                imem_req_valid,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,

    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    output logic                fetch_fault,
    output logic [31:0]         fetch_count
);

    fetch_state_t state;
    fetch_state_t nextState;

    logic rspAccept;     // response captured this cycle
    logic pcAdvance;     // aligned NextPC loaded this cycle

    // Qualified events: each input only matters in the one state that uses it,
    // so stray strobes elsewhere fall out here.
    assign rspAccept = (state == WAIT) && imem_rsp_valid;
    assign pcAdvance = (state == HOLD) && pc_load && isAligned(NextPC);

    // The request address is the PC register itself, never a muxed input.
    assign imem_req_addr = CurrentPC;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state <= BOOT;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and state-decoded outputs (no input-to-output paths).
    // NOTE: every output of this block is given a default first so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        nextState      = state;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        fetch_fault    = 1'b0;
        case (state)
            BOOT: begin
                nextState = REQ;
            end
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    nextState = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (pc_load) begin
                    nextState = isAligned(NextPC) ? REQ : FAULT;
                end
            end
            FAULT: begin
                // Terminal: only reset leaves this state.
                fetch_fault = 1'b1;
                nextState   = FAULT;
            end
            default: begin
                nextState = BOOT;
            end
        endcase
    end

    // PC register: advances only on an accepted, aligned pc_load. A misaligned
    // target leaves the PC pointing at the last good instruction.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            CurrentPC <= RESET_PC;
        end else if (pcAdvance) begin
            CurrentPC <= NextPC;
        end
    end

    // Instruction latch and delivered-instruction counter; the counter wraps
    // silently modulo 2^32.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            instr       <= '0;
            fetch_count <= '0;
        end else if (rspAccept) begin
            instr       <= imem_rsp_data;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit. Inputs change and outputs
// are sampled on the falling clock edge, half a cycle away from the active edge.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        resetl = 1'b1;
    logic [63:0] NextPC = '0;
    logic        pc_load = 1'b0;
    logic [63:0] CurrentPC;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int vectors = 0;
    int miscompares = 0;

    pc_fetch_unit #(.RESET_PC(64'h100)) dut (
        .CLK            (CLK),
        .resetl         (resetl),
        .NextPC         (NextPC),
        .pc_load        (pc_load),
        .CurrentPC      (CurrentPC),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Full snapshot of the architectural outputs against expected values.
    task automatic checkAll(input string tag, input logic [63:0] pc, input logic reqV,
                            input logic [31:0] ins, input logic insV, input logic flt,
                            input logic [31:0] cnt);
        check({tag, ".pc"},    CurrentPC,      pc);
        check({tag, ".addr"},  imem_req_addr,  pc);
        check({tag, ".reqv"},  {63'd0, imem_req_valid}, {63'd0, reqV});
        check({tag, ".instr"}, {32'd0, instr}, {32'd0, ins});
        check({tag, ".iv"},    {63'd0, instr_valid}, {63'd0, insV});
        check({tag, ".fault"}, {63'd0, fetch_fault}, {63'd0, flt});
        check({tag, ".cnt"},   {32'd0, fetch_count}, {32'd0, cnt});
    endtask

    initial begin
        // ---------------- reset and first fetch ----------------
        #2 resetl = 1'b0;
        tick();
        tick();
        checkAll("reset", 64'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
        imem_req_ready = 1'b1;
        resetl = 1'b1;
        tick();                                   // edge 1: BOOT->REQ
        checkAll("boot2req", 64'h100, 1'b1, 32'h0, 1'b0, 1'b0, 32'd0);
        tick();                                   // edge 2: accept -> WAIT
        checkAll("wait1", 64'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hD503201F;
        tick();                                   // edge 3: response -> HOLD
        imem_rsp_valid = 1'b0;
        checkAll("hold1", 64'h100, 1'b0, 32'hD503201F, 1'b1, 1'b0, 32'd1);

        // ---------------- stray response in HOLD ----------------
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hFFFF_FFFF;
        tick();
        imem_rsp_valid = 1'b0;
        checkAll("strayHold", 64'h100, 1'b0, 32'hD503201F, 1'b1, 1'b0, 32'd1);

        // ---------------- advance to 0x104, ready delayed 3 cycles ----------------
        pc_load = 1'b1;
        NextPC  = 64'h104;
        imem_req_ready = 1'b0;
        tick();                                   // HOLD -> REQ
        pc_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // stray response during REQ must be ignored
            imem_rsp_valid = (i < 3);
            imem_rsp_data  = 32'h1234_5678;
            checkAll($sformatf("reqStall%0d", i), 64'h104, 1'b1, 32'hD503201F, 1'b0, 1'b0, 32'd1);
            if (i == 3) begin
                imem_req_ready = 1'b1;
            end
            if (i < 3) begin
                tick();
            end
        end
        imem_rsp_valid = 1'b0;
        tick();                                   // accept -> WAIT
        imem_req_ready = 1'b0;
        checkAll("wait2", 64'h104, 1'b0, 32'hD503201F, 1'b0, 1'b0, 32'd1);

        // pc_load in WAIT is ignored
        pc_load = 1'b1;
        NextPC  = 64'h200;
        tick();
        pc_load = 1'b0;
        checkAll("loadInWait", 64'h104, 1'b0, 32'hD503201F, 1'b0, 1'b0, 32'd1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h8B02_0020;
        tick();
        imem_rsp_valid = 1'b0;
        checkAll("hold2", 64'h104, 1'b0, 32'h8B02_0020, 1'b1, 1'b0, 32'd2);

        // ---------------- misaligned target -> FAULT ----------------
        pc_load = 1'b1;
        NextPC  = 64'h106;
        tick();
        checkAll("fault", 64'h104, 1'b0, 32'h8B02_0020, 1'b0, 1'b1, 32'd2);
        NextPC = 64'h108;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll($sformatf("faultSticky%0d", i), 64'h104, 1'b0, 32'h8B02_0020, 1'b0, 1'b1, 32'd2);
        end
        pc_load = 1'b0;
        imem_rsp_valid = 1'b0;

        // reset clears the fault asynchronously
        #2 resetl = 1'b0;
        #1 checkAll("faultReset", 64'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
        tick();
        resetl = 1'b1;

        // ---------------- fetch 0x100, then reset while in WAIT ----------------
        tick();                                   // BOOT->REQ
        tick();                                   // accept -> WAIT
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h9100_0421;
        tick();                                   // -> HOLD
        imem_rsp_valid = 1'b0;
        checkAll("hold3", 64'h100, 1'b0, 32'h9100_0421, 1'b1, 1'b0, 32'd1);
        pc_load = 1'b1;
        NextPC  = 64'h108;
        tick();                                   // -> REQ
        pc_load = 1'b0;
        tick();                                   // accept -> WAIT
        checkAll("wait3", 64'h108, 1'b0, 32'h9100_0421, 1'b0, 1'b0, 32'd1);
        #2 resetl = 1'b0;
        #1 checkAll("asyncReset", 64'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
        tick();
        // late response straddles reset release; ready held low so it lands in REQ
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h5555_AAAA;
        resetl = 1'b1;
        tick();                                   // BOOT->REQ, response dropped
        checkAll("lateRsp1", 64'h100, 1'b1, 32'h0, 1'b0, 1'b0, 32'd0);
        tick();                                   // still REQ, response dropped
        checkAll("lateRsp2", 64'h100, 1'b1, 32'h0, 1'b0, 1'b0, 32'd0);
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();                                   // accept -> WAIT
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hAAAA_5555;
        tick();                                   // -> HOLD
        imem_rsp_valid = 1'b0;
        checkAll("refetch", 64'h100, 1'b0, 32'hAAAA_5555, 1'b1, 1'b0, 32'd1);

        // ---------------- fetch_count wrap ----------------
        force dut.fetch_count = 32'hFFFF_FFFF;
        #1 release dut.fetch_count;
        pc_load = 1'b1;
        NextPC  = 64'h10C;
        tick();                                   // -> REQ
        pc_load = 1'b0;
        tick();                                   // accept -> WAIT
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hD65F_03C0;
        tick();                                   // -> HOLD, counter wraps
        imem_rsp_valid = 1'b0;
        checkAll("wrap", 64'h10C, 1'b0, 32'hD65F_03C0, 1'b1, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
